wallace_tree_pipe: RTL and testbench

//  Parametrised, pipelined 3:2 carry-save reduction tree: NUM_IN rows of WIDTH bits -> sum/carry pair.

---
 rtl/wallace_pkg.sv | 39 +++
 rtl/wallace_csa_level.sv | 47 ++++
 rtl/wallace_tree_pipe.sv | 101 ++++++++++
 tb/tb_wallace_tree_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Elaboration-time helpers describing the shape of the pipelined 3:2 reduction tree.
// Every function here is evaluated into localparams; none of them becomes logic.
package wallace_pkg;

    function automatic int csa_rows_next(input int n);
        return 32'sd2 * (n / 32'sd3) + (n % 32'sd3);
    endfunction

    function automatic int csa_levels(input int n);
        int l;
        int r;
        l = 32'sd0;
        r = n;
        while (r > 32'sd2) begin
            r = csa_rows_next(r);
            l = l + 32'sd1;
        end
        return l;
    endfunction

    function automatic int csa_rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 32'sd0; i < lvl; i++) r = csa_rows_next(r);
        return r;
    endfunction

    function automatic int num_stages(input int n, input int reg_every);
        return (csa_levels(n) + reg_every - 32'sd1) / reg_every;
    endfunction

    // Last level of stage s; the final stage is cut short at the tree depth.
    function automatic int stage_last_level(input int n, input int reg_every, input int s);
        int e;
        e = (s + 32'sd1) * reg_every;
        return ((e < csa_levels(n)) ? e : csa_levels(n)) - 32'sd1;
    endfunction

endpackage

// File: rtl/wallace_csa_level.sv
// One combinational reduction level: consecutive row triples go through 3:2 compressors,
// leftover rows pass straight through after the compressor outputs.
module csa_nbit #(
    parameter int WIDTH = 132
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-2:0] maj
);
    // The top majority bit would shift out of range, so it is never formed.
    assign sum = a ^ b ^ c;
    assign maj = (a[WIDTH-2:0] & b[WIDTH-2:0]) | (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                 (b[WIDTH-2:0] & c[WIDTH-2:0]);
endmodule

module wallace_csa_level
    import wallace_pkg::*;
#(
    parameter int WIDTH = 132,
    parameter int N_IN  = 33
) (
    input  logic [N_IN*WIDTH-1:0]                rows,
    output logic [csa_rows_next(N_IN)*WIDTH-1:0] red
);
    localparam int N_TRI  = N_IN / 32'sd3;
    localparam int N_LEFT = N_IN % 32'sd3;

    for (genvar t = 0; t < N_TRI; t++) begin : g_tri
        logic [WIDTH-1:0] sum_s;
        logic [WIDTH-2:0] maj_s;
        csa_nbit #(.WIDTH(WIDTH)) u_csa (
            .a   (rows[(3*t)*WIDTH +: WIDTH]),
            .b   (rows[(3*t+1)*WIDTH +: WIDTH]),
            .c   (rows[(3*t+2)*WIDTH +: WIDTH]),
            .sum (sum_s),
            .maj (maj_s)
        );
        assign red[(2*t)*WIDTH +: WIDTH]   = sum_s;
        assign red[(2*t+1)*WIDTH +: WIDTH] = {maj_s, 1'b0};
    end

    for (genvar i = 0; i < N_LEFT; i++) begin : g_left
        assign red[(2*N_TRI+i)*WIDTH +: WIDTH] = rows[(3*N_TRI+i)*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/wallace_tree_pipe.sv
// Pipelined carry-save reduction tree with an elastic valid/ready pipeline, flush and tag sideband.
// A stage register closes every REG_EVERY levels and after the last level.
module wallace_tree_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH     = 132,
    parameter int NUM_IN    = 33,
    parameter int REG_EVERY = 3,
    parameter int TAG_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*NUM_IN-1:0] in_rows,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_sum,
    output logic [WIDTH-1:0]        out_carry,
    output logic [TAG_W-1:0]        out_tag
);
    localparam int L = csa_levels(NUM_IN);
    localparam int S = num_stages(NUM_IN, REG_EVERY);

    logic [S-1:0]     valid_r;
    logic [S-1:0]     ready_s;
    logic [S-1:0]     load_s;
    logic             in_fire_s;
    logic [TAG_W-1:0] tag_r [S];

    // Backward ready chain: a stage can load when empty or when its content leaves this cycle.
    always_comb begin
        ready_s      = '0;
        load_s       = '0;
        ready_s[S-1] = !valid_r[S-1] || out_ready;
        for (int s = S - 32'sd2; s >= 32'sd0; s--) ready_s[s] = !valid_r[s] || ready_s[s+1];
        in_ready  = ready_s[0] && !flush && !rst;
        in_fire_s = in_valid && in_ready;
        load_s[0] = in_fire_s;
        for (int s = 32'sd1; s < S; s++) load_s[s] = ready_s[s] && valid_r[s-1];
    end

    // Valid bits and tags advance together; flush and reset empty every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int s = 32'sd0; s < S; s++) tag_r[s] <= '0;
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            if (ready_s[0]) valid_r[0] <= in_fire_s;
            if (load_s[0])  tag_r[0]   <= in_tag;
            for (int s = 32'sd1; s < S; s++) begin
                if (ready_s[s]) valid_r[s] <= valid_r[s-1];
                if (load_s[s])  tag_r[s]   <= tag_r[s-1];
            end
        end
    end

    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int NI = csa_rows_at(NUM_IN, j);
        localparam int NO = csa_rows_next(NI);
        logic [NI*WIDTH-1:0] lin_s;
        logic [NO*WIDTH-1:0] lout_s;

        if (j == 0) begin : g_src
            assign lin_s = in_rows;
        end else if ((j % REG_EVERY) == 0) begin : g_src
            assign lin_s = g_stg[j/REG_EVERY-1].rows_r;
        end else begin : g_src
            assign lin_s = g_lvl[j-1].lout_s;
        end

        wallace_csa_level #(.WIDTH(WIDTH), .N_IN(NI)) u_lvl (
            .rows (lin_s),
            .red  (lout_s)
        );
    end

    for (genvar s = 0; s < S; s++) begin : g_stg
        localparam int LAST = stage_last_level(NUM_IN, REG_EVERY, s);
        localparam int NR   = csa_rows_at(NUM_IN, LAST + 1);
        logic [NR*WIDTH-1:0] rows_r;

        // Data only moves with a real operation, so the output rows stay zero until the first result.
        always_ff @(posedge clk) begin
            if (rst) begin
                rows_r <= '0;
            end else if (load_s[s]) begin
                rows_r <= g_lvl[LAST].lout_s;
            end
        end
    end

    assign out_valid = valid_r[S-1];
    assign out_tag   = tag_r[S-1];
    assign out_sum   = g_stg[S-1].rows_r[WIDTH-1:0];
    assign out_carry = g_stg[S-1].rows_r[2*WIDTH-1:WIDTH];
endmodule

// File: tb/tb_wallace_tree_pipe.sv
// Scoreboard bench for wallace_tree_pipe: a default-parameter DUT under directed steps plus a
// sweep of parameterisations fed with random vectors, all checked from one initial block.
module tb_wallace_tree_pipe;
    localparam int W      = 132;
    localparam int N      = 33;
    localparam int T      = 8;
    localparam int S_MAIN = 3;
    localparam int NSW    = 5;
    localparam int SW_N [NSW] = '{3, 17, 33, 33, 33};
    localparam int SW_R [NSW] = '{1, 2, 1, 8, 20};
    localparam int SW_S [NSW] = '{1, 3, 8, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [N*W-1:0] in_rows;
    logic [T-1:0]   in_tag, out_tag;
    logic [W-1:0]   out_sum, out_carry;

    wallace_tree_pipe #(.WIDTH(W), .NUM_IN(N), .REG_EVERY(3), .TAG_W(T)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rows(in_rows), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_tag(out_tag)
    );

    logic           sw_valid;
    logic [N*W-1:0] sw_rows;
    logic [T-1:0]   sw_tag;
    logic [NSW-1:0] sw_ir, sw_ov;
    logic [W-1:0]   sw_sum [NSW];
    logic [W-1:0]   sw_carry [NSW];
    logic [T-1:0]   sw_otag [NSW];

    for (genvar k = 0; k < NSW; k++) begin : g_sw
        wallace_tree_pipe #(.WIDTH(W), .NUM_IN(SW_N[k]), .REG_EVERY(SW_R[k]), .TAG_W(T)) u_dut (
            .clk(clk), .rst(rst), .flush(1'b0), .in_valid(sw_valid), .in_ready(sw_ir[k]),
            .in_rows(sw_rows[SW_N[k]*W-1:0]), .in_tag(sw_tag), .out_valid(sw_ov[k]),
            .out_ready(1'b1), .out_sum(sw_sum[k]), .out_carry(sw_carry[k]), .out_tag(sw_otag[k])
        );
    end

    typedef struct {
        logic [W-1:0] sum;
        logic [T-1:0] tag;
        int           acc;
    } exp_t;

    exp_t           q[$];
    logic [N*W-1:0] log_rows [64];
    int             log_cyc [64];
    int             n_log = 0;
    int             rd [NSW];
    int             total = 0;
    int             bad = 0;
    int             fires = 0;
    bit             chk_lat = 1'b1;
    logic           prev_stall = 1'b0;
    logic [W-1:0]   prev_sum, prev_carry;
    logic [T-1:0]   prev_tag;
    logic [T-1:0]   next_tag = 8'h00;
    logic [W-1:0]   m33;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] golden(input logic [N*W-1:0] r, input int n);
        logic [W-1:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) acc = acc + r[i*W +: W];
        return acc;
    endfunction

    task automatic rand_rows(output logic [N*W-1:0] r);
        logic [159:0] tmp;
        for (int i = 0; i < N; i++) begin
            tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
            r[i*W +: W] = tmp[W-1:0];
        end
    endtask

    // Called with inputs already driven at the falling edge; checks, records, then advances one cycle.
    task automatic cycle();
        exp_t e;
        #1;
        if (prev_stall) begin
            chk("hold_sum", out_sum, prev_sum);
            chk("hold_carry", out_carry, prev_carry);
            chk("hold_tag", W'(out_tag), W'(prev_tag));
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL spurious_out observed tag=%0h expected no output", out_tag);
            end else begin
                e = q.pop_front();
                chk("sum", out_sum + out_carry, e.sum);
                chk("tag", W'(out_tag), W'(e.tag));
                if (chk_lat) chk("latency", W'(cyc - e.acc), W'(S_MAIN));
            end
        end
        prev_stall = out_valid && !out_ready && !flush && !rst;
        prev_sum   = out_sum;
        prev_carry = out_carry;
        prev_tag   = out_tag;
        if (flush || rst) begin
            chk("in_ready_kill", W'(in_ready), W'(0));
            q.delete();
        end else if (in_valid && in_ready) begin
            e.sum = golden(in_rows, N);
            e.tag = in_tag;
            e.acc = cyc;
            q.push_back(e);
            fires++;
        end
        for (int k = 0; k < NSW; k++) begin
            if (sw_ov[k]) begin
                if (rd[k] >= n_log) begin
                    total++;
                    bad++;
                    $error("FAIL sw_spurious inst=%0d observed tag=%0h", k, sw_otag[k]);
                end else begin
                    chk("sw_sum", sw_sum[k] + sw_carry[k], golden(log_rows[rd[k]], SW_N[k]));
                    chk("sw_tag", W'(sw_otag[k]), W'(rd[k]));
                    chk("sw_latency", W'(cyc - log_cyc[rd[k]]), W'(SW_S[k]));
                    rd[k]++;
                end
            end
        end
        if (sw_valid && !rst) begin
            for (int k = 0; k < NSW; k++) chk("sw_in_ready", W'(sw_ir[k]), W'(1));
            log_rows[n_log] = sw_rows;
            log_cyc[n_log]  = cyc;
            n_log++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rows = '0; in_tag = '0; sw_valid = 1'b0; sw_rows = '0; sw_tag = '0;
        for (int k = 0; k < NSW; k++) rd[k] = 0;
        @(negedge clk);
        run(2);
        rst = 1'b0;
        #1;
        chk("rst_valid", W'(out_valid), W'(0));
        chk("rst_sum", out_sum, '0);
        chk("rst_carry", out_carry, '0);
        chk("rst_tag", W'(out_tag), W'(0));

        // All rows = 1: result 33 after three stages.
        for (int i = 0; i < N; i++) in_rows[i*W +: W] = W'(1);
        in_valid = 1'b1; in_tag = 8'h5A;
        cycle();
        in_valid = 1'b0;
        run(2);
        #1;
        chk("t1_valid", W'(out_valid), W'(1));
        chk("t1_sum", out_sum + out_carry, W'(33));
        chk("t1_tag", W'(out_tag), W'(8'h5A));
        chk("t1_carry_lsb", W'(out_carry[0]), W'(0));
        cycle();

        // 200 back-to-back random vectors.
        for (int i = 0; i < 200; i++) begin
            rand_rows(in_rows);
            in_valid = 1'b1; in_tag = next_tag; next_tag = next_tag + 8'h01;
            cycle();
        end
        in_valid = 1'b0;
        run(6);
        chk("t2_drain", W'(q.size()), W'(0));

        // Output stall under continuous input: only the pipeline depth gets in.
        chk_lat = 1'b0; out_ready = 1'b0; fires = 0;
        for (int i = 0; i < 10; i++) begin
            rand_rows(in_rows);
            in_valid = 1'b1; in_tag = next_tag; next_tag = next_tag + 8'h01;
            cycle();
        end
        #1;
        chk("t3_accepted", W'(fires), W'(S_MAIN));
        chk("t3_in_ready", W'(in_ready), W'(0));
        in_valid = 1'b0; out_ready = 1'b1;
        run(8);
        chk("t3_drain", W'(q.size()), W'(0));
        chk_lat = 1'b1;

        // All-ones rows: carry-outs must wrap modulo 2^W.
        in_rows = '1; in_valid = 1'b1; in_tag = 8'hC3;
        cycle();
        in_valid = 1'b0;
        run(2);
        #1;
        m33 = '0;
        m33 = m33 - W'(33);
        chk("t4_valid", W'(out_valid), W'(1));
        chk("t4_sum", out_sum + out_carry, m33);
        cycle();

        // Flush, then reset, with three operations in flight and a fresh one offered.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                rand_rows(in_rows);
                in_valid = 1'b1; in_tag = 8'hA0 + 8'(i);
                cycle();
            end
            rand_rows(in_rows);
            in_tag = 8'hEE; out_ready = 1'b0;
            if (pass == 0) flush = 1'b1;
            else rst = 1'b1;
            cycle();
            flush = 1'b0; rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            #1;
            chk("t5_valid_off", W'(out_valid), W'(0));
            if (pass == 1) begin
                chk("t5_rst_sum", out_sum, '0);
                chk("t5_rst_tag", W'(out_tag), W'(0));
            end
            run(5);
            rand_rows(in_rows);
            in_valid = 1'b1; in_tag = 8'hB0 + 8'(pass);
            cycle();
            in_valid = 1'b0;
            run(4);
            chk("t5_drain", W'(q.size()), W'(0));
        end

        // Parameter sweep with random vectors.
        for (int i = 0; i < 30; i++) begin
            rand_rows(sw_rows);
            sw_valid = 1'b1; sw_tag = 8'(n_log);
            cycle();
        end
        sw_valid = 1'b0;
        run(12);
        for (int k = 0; k < NSW; k++) chk("sw_count", W'(rd[k]), W'(n_log));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
